decode_queue_stage: RTL and testbench

- Parametrised successor to the single-slot decode stage.
- A DEPTH-entry instruction queue decouples fetch from decode using a valid/ready handshake.
- Contains the integer register file with write-through bypass, immediate extension, and load-use interlock.
- Drives a registered decode pipeline latch consumed by the execute stage.

---
 rtl/decode_queue_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_queue_stage.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_stage.sv
// Decode stage fronted by a DEPTH-entry instruction queue: register file, immediate
// extension, load-use interlock and the registered decode latch. Optional macro: DECODE_BYPASS_EN.
module decode_queue_stage #(
  parameter int DEPTH = 4,
  parameter int NREGS = 32
) (
  input  logic                     CLK,
  input  logic                     nRST,
  input  logic                     in_valid,
  input  logic [31:0]              in_instr,
  input  logic [31:0]              in_pc,
  output logic                     in_ready,
  input  logic                     flush,
  input  logic                     freeze,
  input  logic                     wb_wen,
  input  logic [4:0]               wb_sel,
  input  logic [31:0]              wb_data,
  input  logic                     ex_dren,
  input  logic [4:0]               ex_rw,
  output logic                     out_valid,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc,
  output logic [4:0]               out_rs,
  output logic [4:0]               out_rt,
  output logic [4:0]               out_rd,
  output logic [31:0]              out_porta,
  output logic [31:0]              out_portb,
  output logic [31:0]              out_imm,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int RW = $clog2(NREGS);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } qent_t;

  qent_t            q_mem [DEPTH];
  logic [AW-1:0]    head_ptr, tail_ptr;
  logic             push, pop, head_ok;
  qent_t            hd;
  logic [4:0]       rs, rt, rd;
  logic [31:0]      imm;
  logic [31:0]      rf [NREGS];
  logic [31:0]      rf_a, rf_b, porta, portb;

  // ---------------------------------------------------------------- queue control
  assign in_ready = (count < CW'(DEPTH));
  assign push     = in_valid & in_ready & ~flush;
  assign head_ok  = (count != '0);
  assign pop      = ~flush & ~freeze & ~stall & head_ok;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else if (flush) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + AW'(1);
      if (pop)  head_ptr <= head_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int i = 0; i < DEPTH; i++) q_mem[i] <= '0;
    end else if (push) begin
      q_mem[tail_ptr] <= '{instr: in_instr, pc: in_pc};
    end
  end

  // ---------------------------------------------------------------- head decode
  assign hd = q_mem[head_ptr];
  assign rs = hd.instr[25:21];
  assign rt = hd.instr[20:16];
  assign rd = hd.instr[15:11];

  always_comb begin
    imm = {{16{hd.instr[15]}}, hd.instr[15:0]};
    case (hd.instr[31:26])
      6'h0C, 6'h0D, 6'h0E: imm = {16'h0000, hd.instr[15:0]};
      6'h0F:               imm = {hd.instr[15:0], 16'h0000};
      default:             imm = {{16{hd.instr[15]}}, hd.instr[15:0]};
    endcase
  end

  assign stall = head_ok & ex_dren & (ex_rw != 5'd0) & ((ex_rw == rs) | (ex_rw == rt));

  // ---------------------------------------------------------------- register file
  // Entry 0 never takes a write; wb_sel values >= NREGS match no entry.
  for (genvar r = 0; r < NREGS; r++) begin : g_rf
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)
        rf[r] <= '0;
      else if ((r != 0) && wb_wen && (wb_sel == 5'(r)))
        rf[r] <= wb_data;
    end
  end

  assign rf_a = (32'(rs) < NREGS) ? rf[rs[RW-1:0]] : '0;
  assign rf_b = (32'(rt) < NREGS) ? rf[rt[RW-1:0]] : '0;

`ifdef DECODE_BYPASS_EN
  logic wb_ok;
  assign wb_ok = wb_wen && (wb_sel != 5'd0) && (32'(wb_sel) < NREGS);
  assign porta = (wb_ok && (wb_sel == rs)) ? wb_data : rf_a;
  assign portb = (wb_ok && (wb_sel == rt)) ? wb_data : rf_b;
`else
  // Overlap with a same-cycle writeback is left to the external hazard unit.
  assign porta = rf_a;
  assign portb = rf_b;
`endif

  // ---------------------------------------------------------------- decode latch
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      out_porta <= '0;
      out_portb <= '0;
      out_imm   <= '0;
    end else if (freeze && !flush) begin
      out_valid <= out_valid;
    end else if (pop) begin
      out_valid <= 1'b1;
      out_instr <= hd.instr;
      out_pc    <= hd.pc;
      out_rs    <= rs;
      out_rt    <= rt;
      out_rd    <= rd;
      out_porta <= porta;
      out_portb <= portb;
      out_imm   <= imm;
    end else begin
      // flush, stall and empty all insert a cleared bubble
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_rs    <= '0;
      out_rt    <= '0;
      out_rd    <= '0;
      out_porta <= '0;
      out_portb <= '0;
      out_imm   <= '0;
    end
  end

endmodule

// File: tb/tb_decode_queue_stage.sv
// Directed bench for decode_queue_stage (DEPTH=4, NREGS=32).
module tb_decode_queue_stage;
  logic        CLK, nRST;
  logic        in_valid, in_ready, flush, freeze;
  logic [31:0] in_instr, in_pc;
  logic        wb_wen, ex_dren;
  logic [4:0]  wb_sel, ex_rw;
  logic [31:0] wb_data;
  logic        out_valid, stall;
  logic [31:0] out_instr, out_pc, out_porta, out_portb, out_imm;
  logic [4:0]  out_rs, out_rt, out_rd;
  logic [2:0]  count;

  int checks = 0;
  int failures = 0;

  decode_queue_stage #(.DEPTH(4), .NREGS(32)) dut (
    .CLK(CLK), .nRST(nRST),
    .in_valid(in_valid), .in_instr(in_instr), .in_pc(in_pc), .in_ready(in_ready),
    .flush(flush), .freeze(freeze),
    .wb_wen(wb_wen), .wb_sel(wb_sel), .wb_data(wb_data),
    .ex_dren(ex_dren), .ex_rw(ex_rw),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc(out_pc),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .out_porta(out_porta), .out_portb(out_portb), .out_imm(out_imm),
    .stall(stall), .count(count)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; in_valid = 0; in_instr = '0; in_pc = '0; flush = 0; freeze = 0;
    wb_wen = 0; wb_sel = '0; wb_data = '0; ex_dren = 0; ex_rw = '0;
    #12;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", out_instr); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", in_ready); end
    nRST = 1'b1;
    tick();
  endtask

  task automatic test_addi();
    in_valid = 1; in_instr = 32'h2001_0005; in_pc = 32'h0;
    tick();
    in_valid = 0;
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL addi_count_push got=%0d exp=1", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL addi_early got=%b exp=0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
    checks++; if (out_rt !== 5'd1) begin failures++; $display("FAIL addi_rt got=%0d exp=1", out_rt); end
    checks++; if (out_imm !== 32'h0000_0005) begin failures++; $display("FAIL addi_imm got=%h exp=00000005", out_imm); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL addi_count got=%0d exp=0", count); end
  endtask

  task automatic test_imm_ext();
    in_valid = 1; in_instr = 32'h3C01_8000; in_pc = 32'h4;
    tick();
    in_instr = 32'h3421_FFFF; in_pc = 32'h8;
    tick();
    checks++; if (out_imm !== 32'h8000_0000) begin failures++; $display("FAIL imm_lui got=%h exp=80000000", out_imm); end
    checks++; if (out_instr !== 32'h3C01_8000) begin failures++; $display("FAIL imm_lui_instr got=%h exp=3c018000", out_instr); end
    in_instr = 32'h2001_FFFF; in_pc = 32'hC;
    tick();
    checks++; if (out_imm !== 32'h0000_FFFF) begin failures++; $display("FAIL imm_ori got=%h exp=0000ffff", out_imm); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL imm_count got=%0d exp=1", count); end
    in_valid = 0;
    tick();
    checks++; if (out_imm !== 32'hFFFF_FFFF) begin failures++; $display("FAIL imm_sext got=%h exp=ffffffff", out_imm); end
    checks++; if (out_pc !== 32'hC) begin failures++; $display("FAIL imm_pc got=%h exp=c", out_pc); end
  endtask

  task automatic test_freeze_wrap();
    logic [31:0] exp_i [4];
    freeze = 1; in_valid = 1;
    for (int k = 0; k < 5; k++) begin
      in_instr = 32'h2000_0010 + 32'(k); in_pc = 32'h100 + 32'(4 * k);
      checks++;
      if (in_ready !== (k < 4)) begin failures++; $display("FAIL frz_ready k=%0d got=%b exp=%b", k, in_ready, (k < 4)); end
      tick();
    end
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL frz_count got=%0d exp=4", count); end
    checks++; if (out_instr !== 32'h2001_FFFF) begin failures++; $display("FAIL frz_hold got=%h exp=2001ffff", out_instr); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL frz_hold_valid got=%b exp=1", out_valid); end
    // Release with a push pending against the full queue: refused this edge, taken next.
    freeze = 0; in_instr = 32'h2000_0015; in_pc = 32'h114;
    tick();
    checks++; if (out_instr !== 32'h2000_0010) begin failures++; $display("FAIL wrap_i0 got=%h exp=20000010", out_instr); end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL wrap_full_pop got=%0d exp=3", count); end
    tick();
    in_valid = 0;
    checks++; if (out_instr !== 32'h2000_0011) begin failures++; $display("FAIL wrap_i1 got=%h exp=20000011", out_instr); end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL wrap_pushpop got=%0d exp=3", count); end
    exp_i[0] = 32'h2000_0012; exp_i[1] = 32'h2000_0013; exp_i[2] = 32'h2000_0015;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (out_instr !== exp_i[k]) begin failures++; $display("FAIL wrap_order k=%0d got=%h exp=%h", k, out_instr, exp_i[k]); end
    end
    checks++; if (out_pc !== 32'h114) begin failures++; $display("FAIL wrap_pc got=%h exp=114", out_pc); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL wrap_empty got=%b exp=0", out_valid); end
  endtask

  task automatic test_stall();
    ex_dren = 1; ex_rw = 5'd3;
    in_valid = 1; in_instr = 32'h2064_0001; in_pc = 32'h180;
    tick();
    in_valid = 0;
    checks++; if (stall !== 1'b1) begin failures++; $display("FAIL stall_flag got=%b exp=1", stall); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL stall_bubble got=%b exp=0", out_valid); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL stall_count got=%0d exp=1", count); end
    ex_dren = 0;
    #1;
    checks++; if (stall !== 1'b0) begin failures++; $display("FAIL stall_clear got=%b exp=0", stall); end
    tick();
    checks++; if (out_instr !== 32'h2064_0001) begin failures++; $display("FAIL stall_latch got=%h exp=20640001", out_instr); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL stall_pop got=%0d exp=0", count); end
  endtask

  task automatic test_writeback();
    logic [31:0] exp_a;
`ifdef DECODE_BYPASS_EN
    exp_a = 32'hDEAD_BEEF;
`else
    exp_a = 32'h0;
`endif
    in_valid = 1; in_instr = 32'h0040_2820; in_pc = 32'h200;
    tick();
    in_valid = 0; wb_wen = 1; wb_sel = 5'd2; wb_data = 32'hDEAD_BEEF;
    tick();
    wb_wen = 0;
    checks++; if (out_porta !== exp_a) begin failures++; $display("FAIL wb_same_cycle got=%h exp=%h", out_porta, exp_a); end
    in_valid = 1; in_pc = 32'h204;
    tick();
    in_valid = 0;
    tick();
    checks++; if (out_porta !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_stored got=%h exp=deadbeef", out_porta); end
    in_valid = 1; in_instr = 32'h0002_0000; in_pc = 32'h208;
    wb_wen = 1; wb_sel = 5'd0; wb_data = 32'h1234_5678;
    tick();
    in_valid = 0;
    tick();
    wb_wen = 0;
    checks++; if (out_porta !== 32'h0) begin failures++; $display("FAIL wb_reg0 got=%h exp=0", out_porta); end
    checks++; if (out_portb !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wb_portb got=%h exp=deadbeef", out_portb); end
  endtask

  task automatic test_flush();
    freeze = 1; in_valid = 1;
    for (int k = 0; k < 3; k++) begin
      in_instr = 32'h2000_0030 + 32'(k); in_pc = 32'h300 + 32'(4 * k);
      tick();
    end
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL flush_fill got=%0d exp=3", count); end
    freeze = 0; flush = 1; in_instr = 32'h2000_0099; in_pc = 32'h399;
    tick();
    flush = 0; in_valid = 0;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL flush_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    checks++; if (out_instr !== 32'h0) begin failures++; $display("FAIL flush_instr got=%h exp=0", out_instr); end
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_dropped got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    in_valid = 1; in_instr = 32'h0040_2820; in_pc = 32'h400;
    tick();
    tick();
    in_valid = 0;
    checks++; if (out_porta !== 32'hDEAD_BEEF) begin failures++; $display("FAIL ar_pre got=%h exp=deadbeef", out_porta); end
    nRST = 0;
    #2;
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL ar_count got=%0d exp=0", count); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ar_valid got=%b exp=0", out_valid); end
    nRST = 1;
    in_valid = 1;
    tick();
    in_valid = 0;
    tick();
    checks++; if (out_porta !== 32'h0) begin failures++; $display("FAIL ar_regfile got=%h exp=0", out_porta); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_imm_ext();
    test_freeze_wrap();
    test_stall();
    test_writeback();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
